// File: rtl/serial_add_sub_if.sv
// serial_add_sub_if: request/result bundle for the bit-serial adder/subtractor.
interface serial_add_sub_if #(parameter int WIDTH = 8);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    modport master (output start, sub, a, b, input busy, done, result, cout, overflow);
    modport slave  (input start, sub, a, b, output busy, done, result, cout, overflow);
endinterface

// File: rtl/serial_add_sub_ctrl.sv
// serial_add_sub_ctrl: bit-serial add/subtract through one reused full-adder stage, LSB first.
module serial_add_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input logic              clk,
    input logic              rst_n,
    serial_add_sub_if.slave  bus
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);
    logic [1:0]       state;
    logic [WIDTH-1:0] a_r, b_r, sh, sh_next;
    logic [WIDTH-1:0] result_r;
    logic [IW-1:0]    idx;
    logic             carry, cout_r, ovf_r;
    logic             fa_a, fa_b, y, co;
    // The single full-adder stage; b_r already holds ~b for subtraction.
    always_comb begin
        fa_a    = a_r[idx];
        fa_b    = b_r[idx];
        y       = fa_a ^ fa_b ^ carry;
        co      = (fa_a & fa_b) | (carry & (fa_a ^ fa_b));
        sh_next = {y, {(WIDTH-1){1'b0}}} | (sh >> 1);
    end
    assign bus.busy     = state == RUN;
    assign bus.done     = state == DONE;
    assign bus.result   = result_r;
    assign bus.cout     = cout_r;
    assign bus.overflow = ovf_r;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_r      <= '0;
            b_r      <= '0;
            sh       <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            result_r <= '0;
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_r   <= bus.a;
                        b_r   <= bus.b ^ {WIDTH{bus.sub}};
                        carry <= bus.sub;
                        idx   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sh    <= sh_next;
                    carry <= co;
                    idx   <= (idx == LAST) ? '0 : idx + IW'(1);
                    // Outputs only change once the final bit has been formed.
                    if (idx == LAST) begin
                        state    <= DONE;
                        result_r <= sh_next;
                        cout_r   <= co;
                        ovf_r    <= carry ^ co;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
